cpu_regfile_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the moxie register file. It takes writeback requests from the execute stage (EX) and the memory/load stage (MEM) and grants one at a time. Each granted write is turned into a clean, isolated `write_enable_o` pulse, because the register file latches on the write-enable edge. A 16-entry pending-write scoreboard lets the decode/issue stage stall on registers that still have a write outstanding.

---
 rtl/cpu_regfile_arbiter.sv | 130 +++++++++++++
 tb/tb_cpu_regfile_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_regfile_arbiter.sv
// Register-file write-port arbiter (EX vs MEM) with a 16-entry pending-write scoreboard.
// Optional macro CPU_REGFILE_ARB_BYPASS_EN enables forwarding of value_o during the write cycle.
module cpu_regfile_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    input  logic [3:0]  ex_index_i,
    input  logic [31:0] ex_value_i,
    output logic        ex_ready_o,
    input  logic        mem_valid_i,
    input  logic [3:0]  mem_index_i,
    input  logic [31:0] mem_value_i,
    output logic        mem_ready_o,
    input  logic        mark_valid_i,
    input  logic [3:0]  mark_index_i,
    input  logic [3:0]  rd_index1_i,
    input  logic [3:0]  rd_index2_i,
    output logic        busy1_o,
    output logic        busy2_o,
    output logic        fwd1_o,
    output logic        fwd2_o,
    output logic        write_enable_o,
    output logic [3:0]  reg_write_index_o,
    output logic [31:0] value_o
);

    typedef enum logic [1:0] {IDLE, WRITE, RECOVER} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] pending_q, pending_d;
    logic        we_q, we_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] val_q, val_d;
    logic        ex_grant, mem_grant;

    // MEM normally wins; EX overtakes once it has been refused MAX_WAIT times in a row.
    always_comb begin
        logic accept;
        logic force_ex;
        accept    = (state_q != WRITE) && !rst_i;
        force_ex  = (wait_cnt_q == 4'(MAX_WAIT));
        ex_grant  = accept && ex_valid_i && (!mem_valid_i || force_ex);
        mem_grant = accept && mem_valid_i && !ex_grant;
    end

    assign ex_ready_o  = ex_grant;
    assign mem_ready_o = mem_grant;

    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        idx_d      = idx_q;
        val_d      = val_q;
        wait_cnt_d = wait_cnt_q;
        pending_d  = pending_q;

        case (state_q)
            IDLE, RECOVER: state_d = (ex_grant || mem_grant) ? WRITE : IDLE;
            WRITE:         state_d = RECOVER;
            default:       state_d = IDLE;
        endcase

        if (ex_grant) begin
            we_d  = 1'b1;
            idx_d = ex_index_i;
            val_d = ex_value_i;
        end else if (mem_grant) begin
            we_d  = 1'b1;
            idx_d = mem_index_i;
            val_d = mem_value_i;
        end

        if (!ex_valid_i || ex_grant)
            wait_cnt_d = 4'd0;
        else if (wait_cnt_q != 4'(MAX_WAIT))
            wait_cnt_d = wait_cnt_q + 4'd1;

        // Clear first so a same-cycle mark of the same register stays pending.
        if (state_q == WRITE)
            pending_d[idx_q] = 1'b0;
        if (mark_valid_i)
            pending_d[mark_index_i] = 1'b1;
    end

`ifdef CPU_REGFILE_ARB_BYPASS_EN
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = (state_q == WRITE) && (rd_index1_i == idx_q)
               && !(mark_valid_i && (mark_index_i == rd_index1_i));
        hit2 = (state_q == WRITE) && (rd_index2_i == idx_q)
               && !(mark_valid_i && (mark_index_i == rd_index2_i));
        fwd1_o  = hit1;
        fwd2_o  = hit2;
        busy1_o = pending_q[rd_index1_i] && !hit1;
        busy2_o = pending_q[rd_index2_i] && !hit2;
    end
`else
    assign fwd1_o  = 1'b0;
    assign fwd2_o  = 1'b0;
    assign busy1_o = pending_q[rd_index1_i];
    assign busy2_o = pending_q[rd_index2_i];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            idx_q      <= 4'd0;
            val_q      <= 32'd0;
            wait_cnt_q <= 4'd0;
            pending_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            wait_cnt_q <= wait_cnt_d;
            pending_q  <= pending_d;
        end
    end

    assign write_enable_o    = we_q;
    assign reg_write_index_o = idx_q;
    assign value_o           = val_q;

endmodule

// File: tb/tb_cpu_regfile_arbiter.sv
// Bench for cpu_regfile_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_cpu_regfile_arbiter;

    localparam int MAX_WAIT = 3;
`ifdef CPU_REGFILE_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, mem_valid_i, mark_valid_i;
    logic [3:0]  ex_index_i, mem_index_i, mark_index_i, rd_index1_i, rd_index2_i;
    logic [31:0] ex_value_i, mem_value_i;
    logic        ex_ready_o, mem_ready_o, busy1_o, busy2_o, fwd1_o, fwd2_o, write_enable_o;
    logic [3:0]  reg_write_index_o;
    logic [31:0] value_o;

    always #5 clk_i = ~clk_i;

    cpu_regfile_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_index_i(ex_index_i), .ex_value_i(ex_value_i), .ex_ready_o(ex_ready_o),
        .mem_valid_i(mem_valid_i), .mem_index_i(mem_index_i), .mem_value_i(mem_value_i), .mem_ready_o(mem_ready_o),
        .mark_valid_i(mark_valid_i), .mark_index_i(mark_index_i),
        .rd_index1_i(rd_index1_i), .rd_index2_i(rd_index2_i),
        .busy1_o(busy1_o), .busy2_o(busy2_o), .fwd1_o(fwd1_o), .fwd2_o(fwd2_o),
        .write_enable_o(write_enable_o), .reg_write_index_o(reg_write_index_o), .value_o(value_o)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: m_we means "a transfer happened on the previous edge", so this cycle pulses.
    bit          m_pend [16];
    bit          m_we;
    logic [3:0]  m_idx;
    logic [31:0] m_val;
    int          m_streak;
    bit          obs_ex_rdy, obs_mem_rdy, obs_busy1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] modelPending();
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = m_pend[i];
        return p;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        m_we = 1'b0; m_idx = 4'd0; m_val = 32'd0; m_streak = 0;
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the model, check registered state.
    task automatic applyStimulus();
        bit acc, exr, memr, f1, f2;
        #3;
        acc  = !m_we && !rst_i;
        exr  = acc && ex_valid_i && (!mem_valid_i || m_streak >= MAX_WAIT);
        memr = acc && mem_valid_i && !exr;
        f1   = BYP && m_we && (rd_index1_i == m_idx) && !(mark_valid_i && mark_index_i == rd_index1_i);
        f2   = BYP && m_we && (rd_index2_i == m_idx) && !(mark_valid_i && mark_index_i == rd_index2_i);
        checkOutput("ex_ready", ex_ready_o, exr);
        checkOutput("mem_ready", mem_ready_o, memr);
        checkOutput("busy1", busy1_o, m_pend[rd_index1_i] && !f1);
        checkOutput("busy2", busy2_o, m_pend[rd_index2_i] && !f2);
        checkOutput("fwd1", fwd1_o, f1);
        checkOutput("fwd2", fwd2_o, f2);
        obs_ex_rdy  = ex_ready_o;
        obs_mem_rdy = mem_ready_o;
        obs_busy1   = busy1_o;
        @(posedge clk_i);
        if (rst_i) begin
            modelReset();
        end else begin
            if (m_we) m_pend[m_idx] = 1'b0;
            if (mark_valid_i) m_pend[mark_index_i] = 1'b1;
            m_streak = (ex_valid_i && !exr) ? ((m_streak + 1 > MAX_WAIT) ? MAX_WAIT : m_streak + 1) : 0;
            m_we = exr || memr;
            if (exr) begin m_idx = ex_index_i; m_val = ex_value_i; end
            else if (memr) begin m_idx = mem_index_i; m_val = mem_value_i; end
        end
        #1;
        checkOutput("write_enable", write_enable_o, m_we);
        checkOutput("reg_write_index", reg_write_index_o, m_idx);
        checkOutput("value", value_o, m_val);
        checkOutput("wait_cnt", dut.wait_cnt_q, m_streak);
        checkOutput("pending", dut.pending_q, modelPending());
    endtask

    initial begin
        int opp;
        bit got;
        rst_i = 1'b1;
        ex_valid_i = 0; mem_valid_i = 0; mark_valid_i = 0;
        ex_index_i = 0; mem_index_i = 0; mark_index_i = 0; rd_index1_i = 0; rd_index2_i = 0;
        ex_value_i = 0; mem_value_i = 0;
        @(posedge clk_i); #1;
        modelReset();
        checkOutput("reset_we", write_enable_o, 1'b0);
        checkOutput("reset_index", reg_write_index_o, 4'd0);
        checkOutput("reset_value", value_o, 32'd0);
        checkOutput("reset_pending", dut.pending_q, 16'd0);
        applyStimulus();
        rst_i = 1'b0;

        // Single EX write to a marked register.
        mark_valid_i = 1; mark_index_i = 4; rd_index1_i = 4; rd_index2_i = 1;
        applyStimulus();
        mark_valid_i = 0;
        ex_valid_i = 1; ex_index_i = 4; ex_value_i = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("t1_ex_ready", obs_ex_rdy, 1'b1);
        checkOutput("t1_busy_marked", obs_busy1, 1'b1);
        checkOutput("t1_pulse", write_enable_o, 1'b1);
        checkOutput("t1_index", reg_write_index_o, 4'd4);
        checkOutput("t1_value", value_o, 32'hDEADBEEF);
        ex_valid_i = 0;
        applyStimulus();
        checkOutput("t1_pulse_end", write_enable_o, 1'b0);
        checkOutput("t1_busy_recover", busy1_o, 1'b0);
        applyStimulus();

        // Simultaneous EX and MEM from IDLE.
        ex_valid_i = 1; ex_index_i = 2; ex_value_i = 32'h11;
        mem_valid_i = 1; mem_index_i = 3; mem_value_i = 32'h22;
        applyStimulus();
        checkOutput("t2_mem_first", obs_mem_rdy, 1'b1);
        checkOutput("t2_ex_wait", obs_ex_rdy, 1'b0);
        checkOutput("t2_pulse1_val", value_o, 32'h22);
        mem_valid_i = 0;
        applyStimulus();
        checkOutput("t2_gap1", write_enable_o, 1'b0);
        applyStimulus();
        checkOutput("t2_ex_from_recover", obs_ex_rdy, 1'b1);
        checkOutput("t2_pulse2", write_enable_o, 1'b1);
        checkOutput("t2_pulse2_val", value_o, 32'h11);
        ex_valid_i = 0;
        applyStimulus();
        checkOutput("t2_gap2", write_enable_o, 1'b0);
        applyStimulus();

        // Starvation guard with MEM permanently valid.
        ex_valid_i = 1; ex_index_i = 10; ex_value_i = 32'hE0E0;
        mem_valid_i = 1;
        opp = 0; got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (!m_we) opp++;
            mem_index_i = 4'($urandom_range(0, 15));
            mem_value_i = $urandom;
            applyStimulus();
            if (obs_ex_rdy) got = 1;
        end
        checkOutput("starve_ex_granted", got, 1'b1);
        checkOutput("starve_by_4th", (opp <= 4), 1'b1);
        ex_valid_i = 0; mem_valid_i = 0;
        applyStimulus();
        checkOutput("starve_wait_clear", dut.wait_cnt_q, 4'd0);

        // Mark and clear hitting the same register.
        mark_valid_i = 1; mark_index_i = 5;
        applyStimulus();
        mark_valid_i = 0;
        ex_valid_i = 1; ex_index_i = 5; ex_value_i = 32'h55;
        applyStimulus();
        ex_valid_i = 0; mark_valid_i = 1; mark_index_i = 5; rd_index1_i = 5;
        applyStimulus();
        mark_valid_i = 0;
        checkOutput("collide_busy", busy1_o, 1'b1);

        // Reset while the pulse is high.
        ex_valid_i = 1; ex_index_i = 9; ex_value_i = 32'h99;
        applyStimulus();
        ex_valid_i = 0;
        checkOutput("rst_pulse_before", write_enable_o, 1'b1);
        rst_i = 1;
        applyStimulus();
        checkOutput("rst_we", write_enable_o, 1'b0);
        checkOutput("rst_index", reg_write_index_o, 4'd0);
        checkOutput("rst_value", value_o, 32'd0);
        checkOutput("rst_pending", dut.pending_q, 16'd0);
        checkOutput("rst_busy1", busy1_o, 1'b0);
        checkOutput("rst_ex_ready", ex_ready_o, 1'b0);
        rst_i = 0;
        applyStimulus();
        checkOutput("rst_no_pulse", write_enable_o, 1'b0);

        // Read a register during its own write cycle.
        mark_valid_i = 1; mark_index_i = 7; rd_index1_i = 7;
        applyStimulus();
        mark_valid_i = 0;
        ex_valid_i = 1; ex_index_i = 7; ex_value_i = 32'h77;
        applyStimulus();
        ex_valid_i = 0;
        #2;
        checkOutput("bypass_fwd1", fwd1_o, BYP);
        checkOutput("bypass_busy1", busy1_o, !BYP);
        applyStimulus();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rst_i        = ($urandom_range(0, 49) == 0);
            ex_valid_i   = $urandom_range(0, 1);
            mem_valid_i  = ($urandom_range(0, 2) != 0);
            mark_valid_i = $urandom_range(0, 1);
            ex_index_i   = 4'($urandom_range(0, 15));
            mem_index_i  = 4'($urandom_range(0, 15));
            mark_index_i = 4'($urandom_range(0, 15));
            rd_index1_i  = 4'($urandom_range(0, 15));
            rd_index2_i  = 4'($urandom_range(0, 15));
            ex_value_i   = $urandom;
            mem_value_i  = $urandom;
            applyStimulus();
        end
        rst_i = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
